// File: rtl/hdmi_feed_pkg.sv
// Shared types and constants for the HDMI pixel feeder and its FIFO storage.
package hdmi_feed_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2
  } feed_state_e;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t    DEFAULT_FILL = 16'h0000;
  localparam logic [10:0] LINE_MAX    = 11'd2047;

endpackage

// File: rtl/pixel_fifo_ram.sv
// Simple dual-port pixel storage: synchronous write, registered read on request.
module pixel_fifo_ram
  import hdmi_feed_pkg::*;
#(
  parameter int DEPTH = 2048
) (
  input  logic                     i_clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  rgb565_t                  i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output rgb565_t                  o_rd_data
);

  rgb565_t r_mem [DEPTH];
  rgb565_t r_rd_data;

  // NOTE: no reset on the array or its read register; a reset would prevent block-RAM inference.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/hdmi_pixel_feeder.sv
// FIFO stage between the image source and the HDMI output: frame realignment on VS,
// priming before streaming, fill colour on underflow, line tracking.
module hdmi_pixel_feeder
  import hdmi_feed_pkg::*;
#(
  parameter int      DEPTH       = 2048,
  parameter int      PRIME_LEVEL = 1024,
  parameter rgb565_t FILL_COLOR  = DEFAULT_FILL,
  parameter logic    VS_POL      = 1'b0
) (
  input  logic                   pixel_clk,
  input  logic                   sys_rst,
  input  logic                   video_vs,
  input  logic [10:0]            h_disp,
  input  logic                   data_req,
  output logic [15:0]            pix_data,
  input  logic [15:0]            wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic                   frame_req,
  output logic                   underflow,
  input  logic                   underflow_clr,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [10:0]            line_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  feed_state_e    r_state;
  logic           r_vs_d;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [LW-1:0]  r_level;
  logic [10:0]    r_pix_cnt;
  logic [10:0]    r_line_cnt;
  logic           r_frame_req;
  logic           r_underflow;
  logic           r_sel_ram;
  rgb565_t        r_fill;

  logic           w_vs_edge;
  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic           w_uf_set;
  logic [10:0]    w_h_last;
  rgb565_t        w_ram_q;

  assign w_vs_edge = (video_vs == VS_POL) && (r_vs_d != VS_POL);
  assign w_full    = (r_level == LW'(DEPTH));
  assign w_empty   = (r_level == '0);
  assign wr_ready  = (r_state != ST_IDLE) && !w_full;
  // A flush wins over a write arriving in the same cycle.
  assign w_push    = wr_valid && wr_ready && !w_vs_edge;
  assign w_pop     = data_req && (r_state == ST_STREAM) && !w_empty;
  assign w_uf_set  = data_req && (r_state == ST_STREAM) && w_empty;
  assign w_h_last  = (h_disp == 11'd0) ? 11'd0 : h_disp - 11'd1;

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
    end else if (w_vs_edge) begin
      r_state <= ST_PRIME;
    end else begin
      case (r_state)
        ST_PRIME: if (r_level >= LW'(PRIME_LEVEL)) r_state <= ST_STREAM;
        default:  r_state <= r_state;
      endcase
    end
  end

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (w_vs_edge) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_vs_d      <= ~VS_POL;
      r_frame_req <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_vs_d      <= video_vs;
      r_frame_req <= w_vs_edge;
      if (w_uf_set)           r_underflow <= 1'b1;
      else if (underflow_clr) r_underflow <= 1'b0;
    end
  end

  // Output select and fill word are both registers; the RAM read register supplies popped data.
  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_sel_ram <= 1'b0;
      r_fill    <= '0;
    end else if (data_req) begin
      r_sel_ram <= w_pop;
      if (!w_pop) r_fill <= FILL_COLOR;
    end
  end

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
    end else if (w_vs_edge) begin
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
    end else if (data_req) begin
      if (r_pix_cnt == w_h_last) begin
        r_pix_cnt <= '0;
        if (r_line_cnt != LINE_MAX) r_line_cnt <= r_line_cnt + 11'd1;
      end else begin
        r_pix_cnt <= r_pix_cnt + 11'd1;
      end
    end
  end

  pixel_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .i_clk     (pixel_clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (wr_data),
    .i_rd_en   (w_pop),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_ram_q)
  );

  assign pix_data   = r_sel_ram ? w_ram_q : r_fill;
  assign frame_req  = r_frame_req;
  assign underflow  = r_underflow;
  assign fifo_level = r_level;
  assign line_cnt   = r_line_cnt;

endmodule

// File: tb/tb_hdmi_pixel_feeder.sv
// Randomized bench for hdmi_pixel_feeder against a queue-based frame/FIFO model.
module tb_hdmi_pixel_feeder;

  localparam int          DEPTH  = 2048;
  localparam int          PRIME  = 1024;
  localparam logic [15:0] FILL   = 16'h0000;
  localparam logic        VS_POL = 1'b0;
  localparam int M_IDLE = 0, M_PRIME = 1, M_STREAM = 2;

  logic        pixel_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        video_vs = ~VS_POL;
  logic [10:0] h_disp = 11'd640;
  logic        data_req = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        underflow_clr = 1'b0;
  logic [15:0] pix_data;
  logic        wr_ready;
  logic        frame_req;
  logic        underflow;
  logic [11:0] fifo_level;
  logic [10:0] line_cnt;

  hdmi_pixel_feeder #(
    .DEPTH(DEPTH), .PRIME_LEVEL(PRIME), .FILL_COLOR(FILL), .VS_POL(VS_POL)
  ) dut (
    .pixel_clk(pixel_clk), .sys_rst(sys_rst), .video_vs(video_vs), .h_disp(h_disp),
    .data_req(data_req), .pix_data(pix_data), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .frame_req(frame_req), .underflow(underflow),
    .underflow_clr(underflow_clr), .fifo_level(fifo_level), .line_cnt(line_cnt)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pixel queue, frame mode, sticky flag and line position.
  logic [15:0] m_q[$];
  int          m_mode;
  logic [15:0] m_pix;
  logic        m_uf;
  logic        m_freq;
  logic        m_vs_prev;
  int          m_line;
  int          m_pil;

  function automatic void model_reset();
    m_q.delete();
    m_mode    = M_IDLE;
    m_pix     = 16'h0000;
    m_uf      = 1'b0;
    m_freq    = 1'b0;
    m_vs_prev = ~VS_POL;
    m_line    = 0;
    m_pil     = 0;
  endfunction

  function automatic void model_clock();
    int  lvl = m_q.size();
    bit  vs_hit = (video_vs == VS_POL) && (m_vs_prev != VS_POL);
    bit  ready = (m_mode != M_IDLE) && (lvl < DEPTH);
    int  hl = (h_disp == 11'd0) ? 1 : int'(h_disp);
    m_vs_prev = video_vs;
    m_freq    = vs_hit;
    if (data_req) begin
      if (m_mode == M_STREAM && lvl > 0) m_pix = m_q.pop_front();
      else                               m_pix = FILL;
    end
    if (data_req && m_mode == M_STREAM && lvl == 0) m_uf = 1'b1;
    else if (underflow_clr)                          m_uf = 1'b0;
    if (wr_valid && ready && !vs_hit) m_q.push_back(wr_data);
    if (vs_hit) m_q.delete();
    if (vs_hit)                                   m_mode = M_PRIME;
    else if (m_mode == M_PRIME && lvl >= PRIME)   m_mode = M_STREAM;
    if (vs_hit) begin
      m_line = 0;
      m_pil  = 0;
    end else if (data_req) begin
      if (m_pil == hl - 1) begin
        m_pil = 0;
        if (m_line < 2047) m_line++;
      end else begin
        m_pil = (m_pil + 1) % 2048;
      end
    end
  endfunction

  task automatic compare();
    check("pix_data", pix_data, m_pix);
    check("wr_ready", wr_ready, (m_mode != M_IDLE) && (m_q.size() < DEPTH));
    check("frame_req", frame_req, m_freq);
    check("underflow", underflow, m_uf);
    check("fifo_level", fifo_level, m_q.size());
    check("line_cnt", line_cnt, m_line);
  endtask

  task automatic step();
    @(posedge pixel_clk);
    model_clock();
    #1;
    compare();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pix"}, pix_data, 16'h0000);
    check({tag, "_ready"}, wr_ready, 1'b0);
    check({tag, "_freq"}, frame_req, 1'b0);
    check({tag, "_uf"}, underflow, 1'b0);
    check({tag, "_level"}, fifo_level, 0);
    check({tag, "_line"}, line_cnt, 0);
  endtask

  task automatic vs_pulse(input bit with_write);
    data_req      = 1'b0;
    underflow_clr = 1'b0;
    video_vs      = VS_POL;
    wr_valid      = with_write;
    wr_data       = 16'($urandom);
    step();
    check("vs_freq_hi", frame_req, 1'b1);
    check("vs_flush", fifo_level, 0);
    wr_valid = 1'b0;
    step();
    check("vs_freq_lo", frame_req, 1'b0);
    step();
    video_vs = ~VS_POL;
    step();
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge pixel_clk);
    #1;
    check_reset("por");
    sys_rst = 1'b0;

    // Nothing accepted before the first VS edge; line counter saturates with h_disp = 0.
    h_disp = 11'd0;
    for (int i = 0; i < 2060; i++) begin
      data_req = 1'b1;
      wr_valid = 1'($urandom);
      wr_data  = 16'($urandom);
      step();
    end
    check("line_sat", line_cnt, 2047);
    data_req = 1'b0;
    wr_valid = 1'b0;
    h_disp   = 11'd640;

    vs_pulse(1'b0);
    check("prime_ready", wr_ready, 1'b1);
    check("prime_level", fifo_level, 0);

    // Prime with a ramp, then read in order with random gaps.
    for (int i = 0; i < PRIME; i++) begin
      wr_valid = 1'b1;
      wr_data  = 16'(i);
      step();
    end
    wr_valid = 1'b0;
    step();
    data_req = 1'b1;
    step();
    check("first_pix", pix_data, 16'h0000);
    step();
    check("second_pix", pix_data, 16'h0001);
    for (int i = 0; i < 5000 && m_q.size() > 2; i++) begin
      data_req = 1'($urandom);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      data_req = 1'b1;
      step();
    end
    check("uf_set", underflow, 1'b1);
    data_req = 1'b0;
    step();
    check("uf_hold", underflow, 1'b1);
    data_req      = 1'b1;
    underflow_clr = 1'b1;
    step();
    check("uf_set_wins", underflow, 1'b1);
    data_req = 1'b0;
    step();
    check("uf_clr", underflow, 1'b0);
    underflow_clr = 1'b0;

    // Fill to full, overrun the source, then push and pop around the full boundary.
    for (int i = 0; i < 2100; i++) begin
      wr_valid = 1'b1;
      wr_data  = 16'($urandom);
      step();
    end
    check("full_level", fifo_level, DEPTH);
    check("full_ready", wr_ready, 1'b0);
    for (int i = 0; i < 16; i++) begin
      data_req = 1'b1;
      wr_data  = 16'($urandom);
      step();
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 500; i++) begin
      data_req = 1'($urandom);
      step();
    end

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      data_req      = ($urandom_range(0, 99) < 50);
      wr_valid      = ($urandom_range(0, 99) < 60);
      wr_data       = 16'($urandom);
      underflow_clr = ($urandom_range(0, 99) < 5);
      step();
    end
    underflow_clr = 1'b0;

    // Bring level to 500, then realign with a concurrent write.
    for (int i = 0; i < 6000 && m_q.size() != 500; i++) begin
      data_req = (m_q.size() > 500);
      wr_valid = (m_q.size() < 500);
      wr_data  = 16'($urandom);
      step();
    end
    check("pre_vs_level", fifo_level, 500);
    h_disp = 11'd4;
    vs_pulse(1'b1);
    check("vs_line", line_cnt, 0);
    for (int i = 0; i < 12; i++) begin
      data_req = 1'b1;
      step();
    end
    check("line_12req", line_cnt, 3);
    data_req = 1'b0;

    // Prime again, stream for a while, then reset asynchronously mid-cycle.
    h_disp = 11'd640;
    for (int i = 0; i < 1100; i++) begin
      wr_valid = 1'b1;
      wr_data  = 16'($urandom);
      step();
    end
    for (int i = 0; i < 200; i++) begin
      data_req = 1'($urandom);
      wr_valid = 1'($urandom);
      wr_data  = 16'($urandom);
      step();
    end
    #2;
    sys_rst = 1'b1;
    #1;
    check_reset("async_rst");
    model_reset();
    repeat (2) @(posedge pixel_clk);
    #1;
    sys_rst = 1'b0;

    for (int i = 0; i < 50; i++) begin
      data_req = 1'($urandom);
      wr_valid = 1'($urandom);
      wr_data  = 16'($urandom);
      step();
    end
    vs_pulse(1'b0);
    for (int i = 0; i < 1030; i++) begin
      data_req = 1'($urandom);
      wr_valid = 1'b1;
      wr_data  = 16'($urandom);
      step();
    end
    for (int i = 0; i < 300; i++) begin
      data_req = 1'($urandom);
      wr_valid = 1'($urandom);
      wr_data  = 16'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
